// File: rtl/l2_ifill_resp_pkg.sv
// l2_ifill_resp shared types and geometry helpers.
// Imported by the responder, its beat assembler and the bench.
`timescale 1ns/1ps
package l2_ifill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    FILL,
    RESP
  } state_e;

  function automatic int unsigned offset_f(
    input int unsigned line_size
  );
    return $clog2(line_size);
  endfunction

  function automatic int unsigned beats_f(
    input int unsigned line_size,
    input int unsigned beat_width
  );
    return (line_size * 8) / beat_width;
  endfunction

  function automatic logic [63:0] line_align(
    input logic [63:0] a,
    input int unsigned off
  );
    return a & ~((64'd1 << off) - 64'd1);
  endfunction

endpackage

// File: rtl/l2_ifill_resp_if.sv
// I$ refill port and memory read channel of l2_ifill_resp.
// slave = responder side, master = I$/memory side.
`timescale 1ns/1ps
interface l2_ifill_resp_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 64,
  parameter int unsigned BEAT_WIDTH = 64
);
  logic                   ic_req_valid_i;
  logic [ADDR_WIDTH-1:0]  ic_req_addr_i;
  logic                   ic_req_ready_o;
  logic                   ic_resp_valid_o;
  logic                   ic_resp_ready_i;
  logic [ADDR_WIDTH-1:0]  ic_resp_addr_o;
  logic [LINE_SIZE*8-1:0] ic_resp_data_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [ADDR_WIDTH-1:0]  mem_req_addr_o;
  logic                   mem_rvalid_i;
  logic [BEAT_WIDTH-1:0]  mem_rdata_i;

  modport slave (
    input  ic_req_valid_i, ic_req_addr_i,
    output ic_req_ready_o,
    output ic_resp_valid_o, ic_resp_addr_o,
    output ic_resp_data_o,
    input  ic_resp_ready_i,
    output mem_req_valid_o, mem_req_addr_o,
    input  mem_req_ready_i,
    input  mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output ic_req_valid_i, ic_req_addr_i,
    input  ic_req_ready_o,
    input  ic_resp_valid_o, ic_resp_addr_o,
    input  ic_resp_data_o,
    output ic_resp_ready_i,
    input  mem_req_valid_o, mem_req_addr_o,
    output mem_req_ready_i,
    output mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/l2_ifill_resp_beat_asm.sv
// Beat assembler: counts burst beats and writes each one
// into its slot of the line register; flags the last beat.
`timescale 1ns/1ps
module l2_ifill_beat_asm #(
  parameter int unsigned BEATS      = 8,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic [BEAT_WIDTH-1:0]       beat_i,
  output logic [BEATS*BEAT_WIDTH-1:0] line_o,
  output logic                        last_o
);
  localparam int unsigned CW = $clog2(BEATS);

  logic [CW-1:0]                      cnt_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   line_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      line_q[cnt_q] <= beat_i;
      cnt_q         <= cnt_q + CW'(1);
    end
  end

  assign line_o = line_q;
  assign last_o = en_i && (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/l2_ifill_resp.sv
// L2 responder for I$ line refills (burst fetch + line assembly).
// Optional one-entry line buffer: define L2_IFILL_LINEBUF_EN.
`timescale 1ns/1ps
module l2_ifill_resp
  import l2_ifill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 64,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  l2_ifill_resp_if.slave  bus_if
);
  localparam int unsigned OFFSET = offset_f(LINE_SIZE);
  localparam int unsigned BEATS  =
    beats_f(LINE_SIZE, BEAT_WIDTH);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    req_rdy_q;
  logic                    mreq_vld_q;
  logic                    resp_vld_q;
  logic [LINE_SIZE*8-1:0]  line;
  logic                    last;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   req_line;

  wire req_fire  = bus_if.ic_req_valid_i & req_rdy_q;
  wire mreq_fire = (state_q == MREQ)
                 & bus_if.mem_req_ready_i;
  wire beat_en   = (state_q == FILL)
                 & bus_if.mem_rvalid_i;

  assign req_line = ADDR_WIDTH'(line_align(
    64'(bus_if.ic_req_addr_i), OFFSET));

  l2_ifill_beat_asm #(
    .BEATS      (BEATS),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_asm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (mreq_fire),
    .en_i   (beat_en),
    .beat_i (bus_if.mem_rdata_i),
    .line_o (line),
    .last_o (last)
  );

`ifdef L2_IFILL_LINEBUF_EN
  // The assembly register doubles as buffer storage: it
  // only changes during a fill, which rewrites valid/tag.
  localparam int unsigned TW = ADDR_WIDTH - OFFSET;

  logic          buf_vld_q;
  logic [TW-1:0] tag_q;
  logic          fill_flush_q;

  assign hit = buf_vld_q & ~flush_i &
    (bus_if.ic_req_addr_i[ADDR_WIDTH-1:OFFSET] == tag_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_vld_q    <= 1'b0;
      tag_q        <= '0;
      fill_flush_q <= 1'b0;
    end else begin
      if (req_fire)     fill_flush_q <= 1'b0;
      else if (flush_i) fill_flush_q <= 1'b1;
      if (flush_i) begin
        buf_vld_q <= 1'b0;
      end else if (last && !fill_flush_q) begin
        buf_vld_q <= 1'b1;
        tag_q     <= addr_q[ADDR_WIDTH-1:OFFSET];
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign hit          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_rdy_q  <= 1'b1;
      mreq_vld_q <= 1'b0;
      resp_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_fire) begin
          addr_q    <= req_line;
          req_rdy_q <= 1'b0;
          if (hit) begin
            state_q    <= RESP;
            resp_vld_q <= 1'b1;
          end else begin
            state_q    <= MREQ;
            mreq_vld_q <= 1'b1;
          end
        end
        MREQ: if (bus_if.mem_req_ready_i) begin
          state_q    <= FILL;
          mreq_vld_q <= 1'b0;
        end
        FILL: if (last) begin
          state_q    <= RESP;
          resp_vld_q <= 1'b1;
        end
        RESP: if (bus_if.ic_resp_ready_i) begin
          state_q    <= IDLE;
          resp_vld_q <= 1'b0;
          req_rdy_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is asserted.
  assign bus_if.ic_req_ready_o  = req_rdy_q & rst_ni;
  assign bus_if.mem_req_valid_o = mreq_vld_q;
  assign bus_if.mem_req_addr_o  = addr_q;
  assign bus_if.ic_resp_valid_o = resp_vld_q;
  assign bus_if.ic_resp_addr_o  = addr_q;
  assign bus_if.ic_resp_data_o  = line;

endmodule

// File: tb/tb_l2_ifill_resp.sv
// Directed bench for l2_ifill_resp (default geometry 64B/64b).
// Line-buffer cases run when L2_IFILL_LINEBUF_EN is defined.
`timescale 1ns/1ps
module tb_l2_ifill_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  l2_ifill_resp_if #(
    .ADDR_WIDTH (32),
    .LINE_SIZE  (64),
    .BEAT_WIDTH (64)
  ) bus ();

  l2_ifill_resp #(
    .ADDR_WIDTH (32),
    .LINE_SIZE  (64),
    .BEAT_WIDTH (64)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus_if  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string        tag,
    input logic [511:0] obs,
    input logic [511:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_line(
    input logic [63:0] base
  );
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++)
      l[64*k +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic run_fill(
    input logic [31:0] a,
    input logic [63:0] base,
    input int          stall,
    input int          gap_at,
    input int          gap_len,
    input int          flush_beat
  );
    logic [31:0] la;
    int          t0;
    la = a & 32'hffff_ffc0;
    chk("idle_rdy", bus.ic_req_ready_o, 1);
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = a;
    step();
    t0 = cyc;
    bus.ic_req_valid_i = 1'b0;
    bus.ic_req_addr_i  = '0;
    chk("mreq_vld", bus.mem_req_valid_o, 1);
    chk("mreq_addr", bus.mem_req_addr_o, la);
    chk("busy_rdy", bus.ic_req_ready_o, 0);
    bus.mem_req_ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_vld", bus.mem_req_valid_o, 1);
      chk("stall_addr", bus.mem_req_addr_o, la);
    end
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    chk("mreq_done", bus.mem_req_valid_o, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        bus.mem_rvalid_i = 1'b0;
        repeat (gap_len) step();
      end
      if (k == 7) chk("pre_vld", bus.ic_resp_valid_o, 0);
      flush = (k == flush_beat);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = base + 64'(k);
      step();
    end
    bus.mem_rvalid_i = 1'b0;
    flush = 1'b0;
    chk("resp_vld", bus.ic_resp_valid_o, 1);
    chk("resp_lat", cyc - t0, 9 + stall + gap_len);
    chk("resp_data", bus.ic_resp_data_o, exp_line(base));
    chk("resp_addr", bus.ic_resp_addr_o, la);
    chk("resp_rdy", bus.ic_req_ready_o, 0);
  endtask

  task automatic take_resp(
    input int           hold,
    input bit           junk,
    input logic [511:0] exp_d,
    input logic [31:0]  exp_a
  );
    bus.ic_resp_ready_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hbad0_0000 + 64'(i);
      end
      step();
      chk("hold_vld", bus.ic_resp_valid_o, 1);
      chk("hold_data", bus.ic_resp_data_o, exp_d);
      chk("hold_addr", bus.ic_resp_addr_o, exp_a);
      chk("hold_rdy", bus.ic_req_ready_o, 0);
    end
    bus.mem_rvalid_i    = 1'b0;
    bus.ic_resp_ready_i = 1'b1;
    step();
    bus.ic_resp_ready_i = 1'b0;
    chk("post_vld", bus.ic_resp_valid_o, 0);
    chk("post_rdy", bus.ic_req_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ic_req_valid_i  = 1'b0;
    bus.ic_req_addr_i   = '0;
    bus.ic_resp_ready_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rvalid_i    = 1'b0;
    bus.mem_rdata_i     = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rdy", bus.ic_req_ready_o, 0);
    chk("rst_mreq", bus.mem_req_valid_o, 0);
    chk("rst_resp", bus.ic_resp_valid_o, 0);
    chk("rst_data", bus.ic_resp_data_o, 0);
    chk("rst_addr", bus.ic_resp_addr_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", bus.ic_req_ready_o, 1);
    step();
    chk("rel_mreq", bus.mem_req_valid_o, 0);

    // basic fill, then slow consumer with stray beats
    run_fill(32'h0000_1234, 64'h0, 0, -1, 0, -1);
    take_resp(5, 1'b1, exp_line(64'h0), 32'h0000_1200);

    // stray beats while idle
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 64'hdead_0000 + 64'(i);
      step();
      chk("idle_rdy2", bus.ic_req_ready_o, 1);
      chk("idle_mreq", bus.mem_req_valid_o, 0);
      chk("idle_data", bus.ic_resp_data_o, exp_line(64'h0));
    end
    bus.mem_rvalid_i = 1'b0;

`ifdef L2_IFILL_LINEBUF_EN
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h0000_1238;
    step();
    bus.ic_req_valid_i = 1'b0;
    chk("hit_vld", bus.ic_resp_valid_o, 1);
    chk("hit_mreq", bus.mem_req_valid_o, 0);
    chk("hit_data", bus.ic_resp_data_o, exp_line(64'h0));
    chk("hit_addr", bus.ic_resp_addr_o, 32'h0000_1200);
    take_resp(0, 1'b0, exp_line(64'h0), 32'h0000_1200);
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_fill(32'h0000_1234, 64'h20, 0, -1, 0, -1);
    take_resp(0, 1'b0, exp_line(64'h20), 32'h0000_1200);
    run_fill(32'h0000_3000, 64'h30, 0, -1, 0, 2);
    take_resp(0, 1'b0, exp_line(64'h30), 32'h0000_3000);
    run_fill(32'h0000_3008, 64'h40, 0, -1, 0, -1);
    take_resp(0, 1'b0, exp_line(64'h40), 32'h0000_3000);
`else
    run_fill(32'h0000_1238, 64'h20, 0, -1, 0, -1);
    take_resp(0, 1'b0, exp_line(64'h20), 32'h0000_1200);
`endif

    // request stall plus a 2-cycle gap between beats 3 and 4
    run_fill(32'h0000_8040, 64'h50, 3, 4, 2, -1);
    take_resp(1, 1'b0, exp_line(64'h50), 32'h0000_8040);

    // reset during beat 4 of a fill
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h0000_4010;
    step();
    bus.ic_req_valid_i  = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 64'h900 + 64'(k);
      step();
    end
    bus.mem_rdata_i = 64'h904;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rdy", bus.ic_req_ready_o, 0);
    chk("mid_mreq", bus.mem_req_valid_o, 0);
    chk("mid_resp", bus.ic_resp_valid_o, 0);
    chk("mid_data", bus.ic_resp_data_o, 0);
    chk("mid_addr", bus.ic_resp_addr_o, 0);
    chk("mid_maddr", bus.mem_req_addr_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 5; k < 8; k++) begin
      bus.mem_rdata_i = 64'h900 + 64'(k);
      step();
      chk("stale_resp", bus.ic_resp_valid_o, 0);
      chk("stale_data", bus.ic_resp_data_o, 0);
    end
    bus.mem_rvalid_i = 1'b0;
    run_fill(32'h0000_2000, 64'h100, 0, -1, 0, -1);
    take_resp(2, 1'b1, exp_line(64'h100), 32'h0000_2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_ifill_resp.md
# l2_ifill_resp

L2-side responder for instruction-cache line refills: accepts one line-fill request at a time from the I$ miss path, fetches the line from backing memory as an in-order burst of narrow beats, assembles the full line, and returns it with its line-aligned address. Sits between the I$ refill port and the L2/memory read channel; the I$ is the only initiator.

## Interface
- ADDR_WIDTH, 32, physical address width
- LINE_SIZE, 64, line size in bytes; must match the I$ line
- BEAT_WIDTH, 64, memory read data width in bits; LINE_SIZE*8/BEAT_WIDTH must be a power of two ≥ 2
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  FENCE.I invalidate of the line buffer
- ic_req_valid_i  in  1  I$ fill request valid
- ic_req_addr_i  in  ADDR_WIDTH  requested address (any byte in the line)
- ic_req_ready_o  out  1  responder can accept a request
- ic_resp_valid_o  out  1  line response valid
- ic_resp_ready_i  in  1  I$ accepts response
- ic_resp_addr_o  out  ADDR_WIDTH  line-aligned address of returned line
- ic_resp_data_o  out  LINE_SIZE*8  line data; byte 0 at bits [7:0]
- mem_req_valid_o  out  1  burst read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  line-aligned burst start address
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  BEAT_WIDTH  read beat data, ascending address order

## Operation
- OFFSET = log2(LINE_SIZE); BEATS = LINE_SIZE*8/BEAT_WIDTH; beat counter width log2(BEATS).
- States: IDLE, MREQ, FILL, RESP.
- IDLE: ic_req_ready_o=1 only here. On ic_req_valid_i: latch addr with low OFFSET bits cleared → MREQ.
- MREQ: mem_req_valid_o=1, mem_req_addr_o=latched line address, held stable until mem_req_ready_i → FILL, beat counter=0.
- FILL: each mem_rvalid_i writes mem_rdata_i into line bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH], k=counter, counter+1; beat k=BEATS-1 → RESP. mem_rvalid_i outside FILL is ignored.
- RESP: ic_resp_valid_o=1; addr/data stable until ic_resp_ready_i → IDLE. No new request accepted until the cycle after the handshake.
- Reset (any state, asynchronous): state IDLE, all outputs 0, counter 0, line buffer invalid; in-flight burst abandoned, later beats ignored.
- flush_i: in any state clears line-buffer valid; does not abort an in-flight fill, but that fill is not captured into the line buffer.

## Timing
- Reset values: ic_req_ready_o=1 after reset release (IDLE), every other output 0, data/addr outputs 0.
- Request accepted at edge N → mem_req_valid_o high in cycle N+1.
- With mem_req_ready_i immediate and beats back-to-back from N+2: last beat at N+BEATS+1, ic_resp_valid_o high at N+BEATS+2 (10 cycles for defaults).
- Gaps in mem_rvalid_i stretch FILL; no timeout.
- ic_resp_valid_o and ic_req_ready_o never high together.

## Configuration
- L2_IFILL_LINEBUF_EN defined: one-entry line buffer holds the last completed line and its tag addr[ADDR_WIDTH-1:OFFSET]. IDLE request whose tag matches a valid buffer goes straight to RESP (ic_resp_valid_o next cycle) with no memory traffic. Each completed fill not hit by flush_i overwrites the buffer.
- Undefined: no buffer storage; every request runs MREQ/FILL.

## Structure
- Package l2_ifill_pkg: state enum typedef, OFFSET/BEATS localparam functions of the parameters, line-address alignment function.
- One sub-module l2_ifill_beat_asm: beat counter, indexed beat write into the line register, last-beat flag; top holds FSM, handshakes, optional line buffer.

## Test plan
- Request 0x0000_1234, memory returns beats 0x0..0x7 back-to-back → mem_req_addr_o=0x0000_1200, ic_resp_addr_o=0x0000_1200, beat k in bits [64k+63:64k], valid at N+10.
- ic_resp_ready_i held low 5 cycles → ic_resp_valid_o, data, addr stable; ic_req_ready_o low; returns IDLE the cycle after ready.
- mem_req_ready_i low 3 cycles, then 2-cycle gap between beats 3 and 4 → request held stable, line assembled correctly, valid delayed by 5 cycles.
- rst_ni low during FILL beat 4, then new request 0x2000 → outputs 0 during reset, stale beats ignored, fresh line for 0x2000 returned.
- With L2_IFILL_LINEBUF_EN: repeat 0x1234 after fill → resp next cycle, mem_req_valid_o stays 0; pulse flush_i, repeat → full memory fill.
- mem_rvalid_i pulsed in IDLE and RESP → no state or data change.
